// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a sync_fifo and its producer/consumer.
// The master side drives write/read requests; the slave side is the FIFO itself.
interface sync_fifo_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) ();
  logic [DATA_W-1:0] D_in;
  logic              w_en;
  logic              r_en;
  logic [DATA_W-1:0] D_out;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   b_wptr;
  logic [ADDR_W:0]   b_rptr;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output D_in, w_en, r_en,
    input  D_out, full, empty, b_wptr, b_rptr, count, overflow, underflow
  );

  modport slave (
    input  D_in, w_en, r_en,
    output D_out, full, empty, b_wptr, b_rptr, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and binary pointers carrying a wrap bit.
// Full/empty/count are decoded from the registered pointers; overflow/underflow are one-cycle pulses.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full_c;
  logic empty_c;
  logic wr_accept;
  logic rd_accept;

  // Equal pointers mean empty; differing only in the wrap bit means full.
  assign empty_c = (wptr_q == rptr_q);
  assign full_c  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                   (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

  always_comb begin
    wr_accept   = bus.w_en && !full_c;
    rd_accept   = bus.r_en && !empty_c;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    dout_d      = dout_q;
    overflow_d  = bus.w_en && full_c;
    underflow_d = bus.r_en && empty_c;
    if (wr_accept) begin
      wptr_d = wptr_q + (ADDR_W+1)'(1);
    end
    if (rd_accept) begin
      rptr_d = rptr_q + (ADDR_W+1)'(1);
      dout_d = mem_q[rptr_q[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; a write in the reset cycle must still be dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= bus.D_in;
    end
  end

  assign bus.D_out     = dout_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.b_wptr    = wptr_q;
  assign bus.b_rptr    = rptr_q;
  assign bus.count     = wptr_q - rptr_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_sync_fifo;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst;

  int checks;
  int errors;

  sync_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus running totals of accepted operations.
  logic [DATA_W-1:0] model_q[$];
  int                total_writes;
  int                total_reads;
  logic [DATA_W-1:0] model_dout;
  bit                model_ovf;
  bit                model_udf;
  bit                model_live;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_step();
    bit was_full;
    bit was_empty;
    if (rst) begin
      model_q.delete();
      total_writes = 0;
      total_reads  = 0;
      model_dout   = '0;
      model_ovf    = 1'b0;
      model_udf    = 1'b0;
      model_live   = 1'b1;
    end else if (model_live) begin
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      model_ovf = bus.w_en && was_full;
      model_udf = bus.r_en && was_empty;
      if (bus.r_en && !was_empty) begin
        model_dout = model_q.pop_front();
        total_reads++;
      end
      if (bus.w_en && !was_full) begin
        model_q.push_back(bus.D_in);
        total_writes++;
      end
    end
  endtask

  initial begin
    model_live = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        checkOutput("D_out",     32'(bus.D_out),     32'(model_dout));
        checkOutput("count",     32'(bus.count),     32'(model_q.size()));
        checkOutput("empty",     32'(bus.empty),     32'(model_q.size() == 0));
        checkOutput("full",      32'(bus.full),      32'(model_q.size() == DEPTH));
        checkOutput("b_wptr",    32'(bus.b_wptr),    32'(total_writes % 16));
        checkOutput("b_rptr",    32'(bus.b_rptr),    32'(total_reads % 16));
        checkOutput("overflow",  32'(bus.overflow),  32'(model_ovf));
        checkOutput("underflow", 32'(bus.underflow), 32'(model_udf));
      end
    end
  end

  // Drive one cycle of requests at the falling edge, then settle after the rising edge.
  task automatic applyStimulus(input bit w, input bit r, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.w_en = w;
    bus.r_en = r;
    bus.D_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    bus.w_en = 1'b1;
    bus.r_en = 1'b1;
    bus.D_in = 16'd77;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst      = 1'b0;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    bus.D_in = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got 0 expected 1 (simulation time limit)");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    bus.D_in = '0;
    repeat (2) @(posedge clk);

    // Reset state, then a read on empty.
    doReset();
    checkOutput("rst_dout",  32'(bus.D_out), 32'd0);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full",  32'(bus.full),  32'd0);
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'd0);
    checkOutput("udf_pulse", 32'(bus.underflow), 32'd1);
    checkOutput("udf_dout",  32'(bus.D_out),     32'd0);
    checkOutput("udf_rptr",  32'(bus.b_rptr),    32'd0);
    applyStimulus(1'b0, 1'b0, 16'd0);
    checkOutput("udf_clear", 32'(bus.underflow), 32'd0);

    // Write 5..8 then read them back.
    for (int v = 5; v <= 8; v++) applyStimulus(1'b1, 1'b0, 16'(v));
    checkOutput("w4_count", 32'(bus.count), 32'd4);
    for (int v = 5; v <= 8; v++) begin
      applyStimulus(1'b0, 1'b1, 16'd0);
      checkOutput("r4_dout", 32'(bus.D_out), 32'(v));
    end
    checkOutput("r4_wptr",  32'(bus.b_wptr), 32'd4);
    checkOutput("r4_rptr",  32'(bus.b_rptr), 32'd4);
    checkOutput("r4_empty", 32'(bus.empty),  32'd1);

    // Fill, overflow, drain.
    doReset();
    for (int v = 1; v <= 8; v++) applyStimulus(1'b1, 1'b0, 16'(v));
    checkOutput("fill_full",  32'(bus.full),  32'd1);
    checkOutput("fill_count", 32'(bus.count), 32'd8);
    applyStimulus(1'b1, 1'b0, 16'd9);
    checkOutput("ovf_pulse", 32'(bus.overflow), 32'd1);
    checkOutput("ovf_wptr",  32'(bus.b_wptr),   32'd8);
    applyStimulus(1'b0, 1'b0, 16'd0);
    checkOutput("ovf_clear", 32'(bus.overflow), 32'd0);
    for (int v = 1; v <= 8; v++) begin
      applyStimulus(1'b0, 1'b1, 16'd0);
      checkOutput("drain_dout", 32'(bus.D_out), 32'(v));
      if (v == 1) checkOutput("drain_full", 32'(bus.full), 32'd0);
    end
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);

    // Pointer wrap over 20 write/read pairs.
    doReset();
    for (int v = 100; v < 120; v++) begin
      applyStimulus(1'b1, 1'b0, 16'(v));
      applyStimulus(1'b0, 1'b1, 16'd0);
      checkOutput("wrap_dout", 32'(bus.D_out), 32'(v));
    end
    checkOutput("wrap_wptr", 32'(bus.b_wptr), 32'd4);
    checkOutput("wrap_rptr", 32'(bus.b_rptr), 32'd4);

    // Simultaneous write and read at count 3.
    doReset();
    for (int v = 10; v <= 12; v++) applyStimulus(1'b1, 1'b0, 16'(v));
    applyStimulus(1'b1, 1'b1, 16'd13);
    checkOutput("sim3_count", 32'(bus.count), 32'd3);
    checkOutput("sim3_dout",  32'(bus.D_out), 32'd10);

    // Simultaneous at count 0: only the write lands.
    doReset();
    applyStimulus(1'b1, 1'b1, 16'd20);
    checkOutput("sim0_count", 32'(bus.count),     32'd1);
    checkOutput("sim0_udf",   32'(bus.underflow), 32'd1);
    checkOutput("sim0_dout",  32'(bus.D_out),     32'd0);

    // Simultaneous at count 8: only the read lands.
    doReset();
    for (int v = 30; v <= 37; v++) applyStimulus(1'b1, 1'b0, 16'(v));
    applyStimulus(1'b1, 1'b1, 16'd99);
    checkOutput("sim8_count", 32'(bus.count),    32'd7);
    checkOutput("sim8_ovf",   32'(bus.overflow), 32'd1);
    checkOutput("sim8_dout",  32'(bus.D_out),    32'd30);
    checkOutput("sim8_full",  32'(bus.full),     32'd0);

    // Reset mid-operation with 5 words stored and a nonzero D_out.
    doReset();
    for (int v = 50; v <= 55; v++) applyStimulus(1'b1, 1'b0, 16'(v));
    applyStimulus(1'b0, 1'b1, 16'd0);
    checkOutput("mid_pre_dout",  32'(bus.D_out), 32'd50);
    checkOutput("mid_pre_count", 32'(bus.count), 32'd5);
    doReset();
    checkOutput("mid_empty", 32'(bus.empty), 32'd1);
    checkOutput("mid_count", 32'(bus.count), 32'd0);
    checkOutput("mid_dout",  32'(bus.D_out), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'd42);
    applyStimulus(1'b0, 1'b1, 16'd0);
    checkOutput("mid_42", 32'(bus.D_out), 32'd42);
    applyStimulus(1'b0, 1'b0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
